// File: rtl/conv5x5_ctrl.sv
// conv5x5_ctrl: loads a 25-tap kernel, streams raster pixels through four line buffers into a
// sliding 5x5 window for an external MAC, and registers the MAC result onto an output stream.
module conv5x5_ctrl #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int DATA_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_SIZE-1:0]   bias_in,
    input  logic                   relu_en_in,
    input  logic                   k_valid,
    output logic                   k_ready,
    input  logic [DATA_SIZE-1:0]   k_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [DATA_SIZE-1:0]   pix_data,
    output logic [25*DATA_SIZE-1:0] win_matrix,
    output logic [25*DATA_SIZE-1:0] ker_matrix,
    output logic [DATA_SIZE-1:0]   bias_out,
    output logic                   relu_1_en,
    input  logic [DATA_SIZE-1:0]   mac_dout,
    output logic                   out_valid,
    output logic [DATA_SIZE-1:0]   out_data,
    output logic [4:0]             out_row,
    output logic [4:0]             out_col,
    output logic                   busy,
    output logic                   done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [2:0] {IDLE, LOAD_K, RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             k_cnt_q, k_cnt_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic [DATA_SIZE-1:0]   ker_q [25];
    logic [DATA_SIZE-1:0]   ker_d [25];
    logic [DATA_SIZE-1:0]   bias_q, bias_d;
    logic                   relu_q, relu_d;
    logic                   k_ready_q, k_ready_d;
    logic                   pix_ready_q, pix_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pend_q, pend_d;
    logic [4:0]             prow_q, prow_d;
    logic [4:0]             pcol_q, pcol_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]   out_data_q, out_data_d;
    logic [4:0]             out_row_q, out_row_d;
    logic [4:0]             out_col_q, out_col_d;
    logic [DATA_SIZE-1:0]   lb_q [4][IMG_W];
    logic [DATA_SIZE-1:0]   win_q [5][5];
    logic                   k_acc, pix_acc, last_col, last_row, win_ok;

    always_comb begin
        k_acc    = state_q == LOAD_K && k_valid;
        pix_acc  = state_q == RUN && pix_valid;
        last_col = col_q == CW'(IMG_W - 1);
        last_row = row_q == RW'(IMG_H - 1);
        win_ok   = row_q >= RW'(4) && col_q >= CW'(4);
        state_d  = state_q;
        k_cnt_d  = k_cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        ker_d    = ker_q;
        bias_d   = bias_q;
        relu_d   = relu_q;
        case (state_q)
            IDLE: begin
                state_d = start ? LOAD_K : IDLE;
                bias_d  = start ? bias_in : bias_q;
                relu_d  = start ? relu_en_in : relu_q;
            end
            LOAD_K: if (k_acc) begin
                ker_d[k_cnt_q] = k_data;
                k_cnt_d        = k_cnt_q == 5'd24 ? '0 : k_cnt_q + 5'd1;
                state_d        = k_cnt_q == 5'd24 ? RUN : LOAD_K;
            end
            RUN: if (pix_acc) begin
                col_d   = last_col ? '0 : col_q + CW'(1);
                row_d   = last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
                state_d = last_col && last_row ? FLUSH : RUN;
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // The window completed at this edge is seen by the MAC next cycle, so capture one edge later.
        pend_d      = pix_acc && win_ok;
        prow_d      = 5'(row_q - RW'(4));
        pcol_d      = 5'(col_q - CW'(4));
        out_valid_d = pend_q;
        out_data_d  = pend_q ? mac_dout : out_data_q;
        out_row_d   = pend_q ? prow_q : out_row_q;
        out_col_d   = pend_q ? pcol_q : out_col_q;
        k_ready_d   = state_d == LOAD_K;
        pix_ready_d = state_d == RUN;
        busy_d      = state_d != IDLE;
        done_d      = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ker_q       <= '{default: '0};
            bias_q      <= '0;
            relu_q      <= 1'b0;
            k_ready_q   <= 1'b0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            prow_q      <= '0;
            pcol_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ker_q       <= ker_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            k_ready_q   <= k_ready_d;
            pix_ready_q <= pix_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            prow_q      <= prow_d;
            pcol_q      <= pcol_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    // Line buffers and window carry no reset: their contents are only observed once refilled.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    win_q[r][c] <= win_q[r][c+1];
            win_q[0][4]    <= lb_q[3][col_q];
            win_q[1][4]    <= lb_q[2][col_q];
            win_q[2][4]    <= lb_q[1][col_q];
            win_q[3][4]    <= lb_q[0][col_q];
            win_q[4][4]    <= pix_data;
            lb_q[3][col_q] <= lb_q[2][col_q];
            lb_q[2][col_q] <= lb_q[1][col_q];
            lb_q[1][col_q] <= lb_q[0][col_q];
            lb_q[0][col_q] <= pix_data;
        end
    end

    always_comb begin
        win_matrix = '0;
        ker_matrix = '0;
        for (int e = 0; e < 25; e++) begin
            win_matrix[DATA_SIZE*(25-e)-1 -: DATA_SIZE] = win_q[e/5][e%5];
            ker_matrix[DATA_SIZE*(25-e)-1 -: DATA_SIZE] = ker_q[e];
        end
    end

    assign k_ready   = k_ready_q;
    assign pix_ready = pix_ready_q;
    assign bias_out  = bias_q;
    assign relu_1_en = relu_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_conv5x5_ctrl.sv
// tb_conv5x5_ctrl: directed passes with a queue of expected strobes checked by a separate monitor.
// The MAC is a sign-magnitude stand-in: sum(w*k)/128 + bias, saturated, optional ReLU.
module tb_conv5x5_ctrl;
    logic         clk = 1'b0;
    logic         rst, start, relu_en_in, k_valid, pix_valid;
    logic [7:0]   bias_in, k_data, pix_data, bias_out, mac_dout, out_data;
    logic         k_ready, pix_ready, relu_1_en, out_valid, busy, done;
    logic [199:0] win_matrix, ker_matrix;
    logic [4:0]   out_row, out_col;

    typedef struct {
        int row;
        int col;
        int data;
        int e0;
        bit chk_e0;
        int cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0, cyc = 0, strobes = 0, dones = 0, last_strobe = -10;
    logic [7:0] prev_e0 = '0;

    conv5x5_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in), .relu_en_in(relu_en_in),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_matrix(win_matrix), .ker_matrix(ker_matrix), .bias_out(bias_out),
        .relu_1_en(relu_1_en), .mac_dout(mac_dout), .out_valid(out_valid),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int smv(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic logic [7:0] mac(input logic [199:0] w, input logic [199:0] k,
                                       input logic [7:0] b, input logic relu);
        int acc = 0;
        int r;
        for (int e = 0; e < 25; e++) acc += smv(w[8*(25-e)-1 -: 8]) * smv(k[8*(25-e)-1 -: 8]);
        r = acc / 128 + smv(b);
        r = r > 127 ? 127 : (r < -127 ? -127 : r);
        r = (relu && r < 0) ? 0 : r;
        return r < 0 ? {1'b1, 7'(-r)} : {1'b0, 7'(r)};
    endfunction

    assign mac_dout = mac(win_matrix, ker_matrix, bias_out, relu_1_en);

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                strobes++;
                last_strobe = cyc;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got row %0d col %0d with nothing expected", out_row, out_col);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("out_row", out_row, e.row);
                    chk("out_col", out_col, e.col);
                    if (e.data >= 0) chk("out_data", out_data, e.data);
                    if (e.chk_e0) chk("win_elem0", prev_e0, e.e0);
                end
            end
            if (done) begin
                dones++;
                chk("done_after_last_strobe", cyc, last_strobe + 1);
                chk("queue_empty_at_done", q.size(), 0);
            end
            prev_e0 = win_matrix[199:192];
        end
    end

    task automatic check_reset_state();
        chk("rst_busy", busy, 0);
        chk("rst_k_ready", k_ready, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_relu", relu_1_en, 0);
        chk("rst_bias", bias_out, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rowcol", {out_row, out_col}, 0);
        chk("rst_kernel", ker_matrix, 0);
    endtask

    task automatic run_pass(input logic [199:0] kvec, input logic [7:0] bias, input logic relu,
                            input int mode, input logic [7:0] pval, input int exp_data,
                            input bit chk_e0, input int abort_at, input bit gaps, input int inject_at);
        int n = 0;
        int s0, d0;
        logic [7:0] p;
        @(negedge clk);
        start = 1; bias_in = bias; relu_en_in = relu;
        @(negedge clk);
        start = 0; bias_in = 8'hEE; relu_en_in = ~relu;
        chk("busy_after_start", busy, 1);
        chk("k_ready_after_start", k_ready, 1);
        chk("bias_latched", bias_out, bias);
        chk("relu_latched", relu_1_en, relu);
        for (int t = 0; t < 25; t++) begin
            if (t == 10) begin
                k_valid = 0;
                @(negedge clk);
            end
            k_valid = 1; k_data = kvec[8*(25-t)-1 -: 8];
            @(negedge clk);
        end
        k_valid = 0;
        chk("ker_matrix_loaded", ker_matrix, kvec);
        chk("pix_ready_in_run", pix_ready, 1);
        chk("k_ready_in_run", k_ready, 0);
        s0 = strobes;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                if (n == abort_at) begin
                    rst = 1; pix_valid = 0;
                    @(negedge clk);
                    rst = 0;
                    q.delete();
                    check_reset_state();
                    d0 = dones;
                    repeat (10) @(negedge clk);
                    chk("no_done_after_reset", dones, d0);
                    return;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    pix_valid = 0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                p = mode == 0 ? 8'($urandom) : (mode == 1 ? pval : 8'(r * 32 + c));
                pix_valid = 1; pix_data = p;
                if (n == inject_at) begin
                    start = 1; bias_in = 8'h55; relu_en_in = ~relu; k_valid = 1; k_data = 8'hFF;
                end
                if (r >= 4 && c >= 4)
                    q.push_back('{r - 4, c - 4, exp_data, ((r - 4) * 32 + c - 4) % 256, chk_e0, cyc + 2});
                @(negedge clk);
                start = 0; k_valid = 0;
                n++;
            end
        end
        pix_valid = 0;
        chk("pix_ready_drops", pix_ready, 0);
        d0 = dones;
        for (int i = 0; i < 20 && dones == d0; i++) @(negedge clk);
        chk("done_pulse_seen", dones, d0 + 1);
        chk("strobe_count", strobes - s0, 784);
        chk("busy_after_done", busy, 0);
        chk("kernel_held", ker_matrix, kvec);
        chk("bias_held", bias_out, bias);
        chk("relu_held", relu_1_en, relu);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] k_ctr, k_tap0, k_all2;
        k_ctr  = 200'h40 << 96;
        k_tap0 = 200'h40 << 192;
        k_all2 = {25{8'h02}};
        rst = 1; start = 0; bias_in = 0; relu_en_in = 0;
        k_valid = 0; k_data = 0; pix_valid = 0; pix_data = 0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 0;
        @(negedge clk);
        run_pass('0, 8'h10, 0, 0, 8'h00, 8'h10, 0, -1, 0, -1);
        run_pass(k_ctr, 8'h00, 0, 1, 8'h40, 8'h20, 0, -1, 0, 300);
        run_pass(k_ctr, 8'h00, 0, 1, 8'hC0, 8'hA0, 0, -1, 0, -1);
        run_pass(k_ctr, 8'h00, 1, 1, 8'hC0, 8'h00, 0, -1, 0, -1);
        run_pass(k_tap0, 8'h00, 0, 2, 8'h00, -1, 1, -1, 1, -1);
        run_pass('0, 8'h10, 0, 0, 8'h00, 8'h10, 0, 500, 0, -1);
        run_pass(k_all2, 8'h05, 0, 1, 8'h40, 8'h1E, 0, -1, 0, -1);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv5x5_ctrl.md
Name: conv5x5_ctrl

Overview:
Sequences one 5x5 convolution pass for a single input/output channel pair of the LeNet conv layers.
- Loads a 25-tap kernel, then accepts a raster-order pixel stream into line buffers and forms the sliding 5x5 window.
- Drives the external combinational multiply-accumulate datapath (window matrix, kernel matrix, bias, ReLU enable) and registers its result onto an output stream.
- Sits between the feature-map RAM reader and the pooling stage.

Parameters:
IMG_W, 32, input row width in pixels (>=5)
IMG_H, 32, input rows (>=5)
DATA_SIZE, 8, pixel/weight width; MAC packing is fixed to 25 elements

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, starts a pass (honoured in IDLE only)
bias_in  in  8  bias, latched on start
relu_en_in  in  1  ReLU enable, latched on start
k_valid  in  1  kernel byte valid
k_ready  out  1  high in LOAD_K
k_data  in  8  kernel byte, row-major tap order 0..24
pix_valid  in  1  pixel valid
pix_ready  out  1  high in RUN
pix_data  in  8  pixel, raster order
win_matrix  out  200  to MAC matrix1
ker_matrix  out  200  to MAC matrix2
bias_out  out  8  to MAC bias
relu_1_en  out  1  to MAC relu_1_en
mac_dout  in  8  MAC result (combinational from the above)
out_valid  out  1  one-cycle strobe per output pixel
out_data  out  8  registered mac_dout
out_row  out  5  output row index 0..IMG_H-5
out_col  out  5  output column index 0..IMG_W-5
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports named clk and rst.
- Reset: state=IDLE; all counters 0; k_ready, pix_ready, out_valid, done, busy, relu_1_en = 0; out_data, out_row, out_col, bias_out = 0; kernel register = 0. Line buffer and window contents are don't-care.
- Packing: element e = r*5+c (r,c = 0..4, r0 = oldest row, c0 = leftmost column) occupies bits [8*(25-e)-1 -: 8] of win_matrix and ker_matrix. Element 0 is in the MSBs.
- IDLE:
  - start=1 latches bias_in into bias_out and relu_en_in into relu_1_en, then goes to LOAD_K.
  - start in any other state is ignored.
- LOAD_K:
  - k_ready=1. Each cycle with k_valid=1 writes k_data to tap k_cnt and increments k_cnt.
  - The 25th accepted byte moves the block to RUN. k_cnt clears on exit.
  - k_valid outside LOAD_K is ignored.
- RUN:
  - pix_ready=1. On each accepted pixel (pix_valid=1):
    - The new window column is {lb3[col], lb2[col], lb1[col], lb0[col], pix_data}, top to bottom.
    - Line buffers shift vertically at col: lb3<=lb2, lb2<=lb1, lb1<=lb0, lb0<=pix_data.
    - The window shifts left one column and the new column enters at c4.
    - col increments; at IMG_W-1, col wraps to 0 and row increments.
  - A window is valid when the accepted pixel has row>=4 and col>=4. Stale columns from the previous row are therefore never emitted.
  - Pixels not accepted (pix_valid=0) stall all state.
- Output timing:
  - Pixel accepted at edge E completes a valid window: at edge E+1, out_data<=mac_dout, out_row<=row-4, out_col<=col-4, out_valid=1 for exactly one cycle.
  - No output backpressure; the consumer must take every strobe.
  - Back-to-back pixels give back-to-back strobes.
- Pass end:
  - Acceptance of pixel (IMG_H-1, IMG_W-1) moves the block to FLUSH. pix_ready=0 from the next cycle.
  - FLUSH lasts one cycle and emits the final output.
  - Then DONE lasts one cycle with done=1, then IDLE. busy falls together with the return to IDLE.
- Output count: exactly (IMG_W-4)*(IMG_H-4) strobes per pass, 784 at default.
- Reset mid-pass (any state): immediate return to the reset values above. A partial output stream is abandoned; no done pulse.
- The kernel register and bias_out hold after DONE until the next start.

Test Plan:
- Kernel all 0x00, bias_in=0x10, relu_en_in=0, 1024 arbitrary pixels -> 784 strobes, all out_data=0x10; done pulses one cycle after the last strobe; out_row/out_col sweep 0..27 in raster order.
- Kernel tap 12 (centre)=0x40, others 0; all pixels 0x40; bias 0 -> every out_data=0x20. ker_matrix bits [103:96]=0x40, all other bytes 0.
- Same kernel, all pixels 0xC0: relu_en_in=0 -> out_data=0xA0; relu_en_in=1 -> out_data=0x00. Confirms relu_1_en is latched at start.
- Pixel value = (row*32+col) mod 256, random pix_valid gaps, kernel with tap 0 only -> each strobe's win_matrix element 0 equals pixel(out_row, out_col). The strobe comes exactly one edge after the completing pixel is accepted, and stalls produce no extra strobes.
- rst asserted after 500 pixels -> next cycle busy=0, out_valid=0, state IDLE, no done. A new start with a full kernel and 1024 pixels then yields a clean 784-strobe pass.
- start pulsed during RUN, and k_valid asserted during RUN -> both ignored; kernel and output stream unchanged.
